fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_stage.sv | 58 +++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-path types and constants.
//   fetch_entry_t    : {pc, instr} pair carried through the fetch FIFO
//   RESET_PC_DEFAULT : default PC loaded on reset
package mips_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of fetch entries with push/pop/flush.
//   CLK   in  : clock, rising edge
//   RESET in  : asynchronous active-low reset
//   push  in  : enqueue din (ignored when full unless popping)
//   pop   in  : dequeue head (ignored when empty)
//   flush in  : drop all entries, overrides push/pop
//   din   in  : entry to enqueue
//   count out : number of valid entries (0..2)
//   head  out : oldest entry, registered
module fetch_fifo
    import mips_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t tail;
    logic do_pop, do_push;
    logic [1:0] slot;
    // slot is where a new entry lands once any same-edge pop has shifted the queue
    always_comb begin
        do_pop  = pop && count != 2'd0;
        do_push = push && (count != 2'd2 || do_pop);
        slot    = count - {1'b0, do_pop};
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) head <= tail;
            if (do_push && slot == 2'd0) head <= din;
            if (do_push && slot != 2'd0) tail <= din;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register feeding a 2-entry fetch FIFO toward decode.
//   CLK            in  : clock, rising edge
//   RESET          in  : asynchronous active-low reset
//   imem_addr      out : word address pc[IMEM_AW+1:2]
//   imem_data      in  : combinational instruction for imem_addr
//   redirect_valid in  : load redirect_pc and flush
//   redirect_pc    in  : redirect target (low two bits dropped)
//   dec_ready      in  : decode accepts head entry
//   dec_valid      out : head entry valid
//   dec_instr      out : head instruction
//   dec_pc         out : head PC
//   dec_pcplus4    out : head PC + 4
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 6
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               dec_ready,
    output logic               dec_valid,
    output logic [31:0]        dec_instr,
    output logic [31:0]        dec_pc,
    output logic [31:0]        dec_pcplus4
);
    logic [31:0]  pc;
    logic [1:0]   count;
    fetch_entry_t head;
    logic         push, pop;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign dec_valid = count != 2'd0;
    assign pop       = dec_valid && dec_ready;
    assign push      = !redirect_valid && (count != 2'd2 || pop);
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;
    // gated so an empty stage (including after reset) presents zero
    assign dec_pcplus4 = dec_valid ? head.pc + 32'd4 : '0;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc & ~32'd3;
        else if (push) pc <= pc + 32'd4;
    end
    fetch_fifo u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: pc, instr: imem_data}),
        .count (count),
        .head  (head)
    );
endmodule
